debug_run_controller: RTL and testbench
=======================================

Name: debug_run_controller

Overview:
- Sequences the 5-stage MIPS pipeline while debug mode is on: free-run, single-step, halt, and pipeline-latch dump over the UART transmitter.
- Sits between the UART command decoder and the pipeline.
- Drives the global stop_debug stall, the 7-bit latch-mux select and the UART TX byte handshake.
- Counts executed cycles for the host.

Parameters:
- NUM_LATCH_WORDS, 24, number of 32-bit latch-mux words dumped (select values 0..N-1, N ≤ 128).
- HALT_INSTR, 32'hFC000000, instruction word in IF that ends a RUN.
- MUX_LATENCY, 2, cycles from latch_sel change to valid latch_data (1..7).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command strobe.
- cmd  in  2  00 RUN, 01 STEP, 10 HALT, 11 DUMP.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- if_instruction  in  32  instruction currently in IF/ID.
- stop_debug  out  1  1 = pipeline frozen.
- latch_sel  out  7  latch-mux select.
- latch_data  in  32  latch-mux output.
- tx_start  out  1  one-cycle pulse; load tx_data into UART TX.
- tx_data  out  8  byte to transmit.
- tx_done  in  1  one-cycle pulse; UART finished the byte.
- halted  out  1  1 in IDLE.
- cycle_count  out  32  unfrozen cycles since reset.

Behaviour:
- All state changes on the rising clk edge. reset=0 is sampled synchronously and overrides everything, including mid-dump and mid-run.
- Reset values: state IDLE, stop_debug=1, latch_sel=0, tx_start=0, tx_data=0, cmd_ready=1, halted=1, cycle_count=0.
- All outputs are registered.

States:
- IDLE, RUN, STEP, DUMP_SEL, DUMP_LOAD, DUMP_TX, DUMP_WAIT.
- IDLE: stop_debug=1, cmd_ready=1.
  - RUN cmd → RUN.
  - STEP cmd → STEP.
  - DUMP cmd → DUMP_SEL with word index k=0.
  - HALT cmd: no-op.
- RUN: stop_debug=0 from the cycle after acceptance, cmd_ready=1.
  - Goes to IDLE when a HALT cmd is accepted, or when if_instruction==HALT_INSTR is sampled. stop_debug=1 from the next cycle.
  - RUN, STEP and DUMP cmds are accepted and dropped.
  - If both halt conditions occur in the same cycle, there is a single transition.
- STEP: stop_debug=0 for exactly one cycle, then IDLE. cmd_ready=0.
- cycle_count increments by 1 on every cycle with stop_debug=0. Wraps modulo 2^32.

Dump (stop_debug stays 1, cmd_ready=0, halted=0):
- DUMP_SEL: latch_sel=k. Wait MUX_LATENCY cycles, then DUMP_LOAD.
- DUMP_LOAD: capture latch_data into a 32-bit shift register, byte counter b=0 → DUMP_TX.
- DUMP_TX: tx_data = byte b, MSB first ([31:24] first). tx_start=1 for this one cycle → DUMP_WAIT.
- DUMP_WAIT: tx_done is sampled only here; a tx_done outside DUMP_WAIT is ignored. On tx_done:
  - b<3 → b+1, DUMP_TX.
  - b=3 and k<N-1 → k+1, DUMP_SEL.
  - b=3 and k=N-1 → send the 4 bytes of cycle_count (snapshot at DUMP acceptance, MSB first), then IDLE with latch_sel=0.
- A dump sends 4·N+4 bytes in total.
- No timeout: DUMP_WAIT holds indefinitely until tx_done or reset.
- A cmd_valid during STEP or dump is not accepted; the source must hold it until cmd_ready=1.

Test Plan:
- Reset: hold reset=0 for 3 cycles with cmd_valid=1 → stop_debug=1, halted=1, cycle_count=0, tx_start never pulses.
- STEP: accept STEP twice from IDLE → stop_debug low for exactly 1 cycle each time; cycle_count=2; halted returns to 1 one cycle after each step.
- RUN until halt: accept RUN, drive if_instruction=32'hFC000000 on the 10th unfrozen cycle → stop_debug=1 the following cycle, cycle_count=10, halted=1. A HALT cmd in the same cycle produces identical results.
- HALT cmd: accept RUN then HALT 5 cycles later → cycle_count=5. A DUMP cmd issued during RUN is dropped: no tx_start.
- DUMP, N=24: latch_data = 32'hA0000000|latch_sel; tx_done returned 3 cycles after each tx_start.
  - Exactly 100 tx_start pulses.
  - Byte stream: A0 00 00 00, A0 00 00 01, … A0 00 00 17, then cycle_count MSB-first.
  - latch_sel=0 at the end; cmd_ready=0 throughout the dump.
  - A tx_done pulse injected during DUMP_SEL is ignored.
- Reset mid-dump: assert reset=0 while in DUMP_WAIT on word 5 → next cycle in IDLE, tx_start=0, latch_sel=0, cmd_ready=1. A new DUMP restarts at word 0.

Source files
------------

// File: rtl/debug_run_controller.sv
// Debug run controller for the 5-stage MIPS pipeline.
// Handles free-run, single-step and halt, and dumps the pipeline latches
// followed by a cycle-count snapshot over the UART transmitter.
module debug_run_controller #(
  parameter int unsigned NUM_LATCH_WORDS = 24,
  parameter logic [31:0] HALT_INSTR      = 32'hFC000000,
  parameter int unsigned MUX_LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd,
  output logic        cmd_ready,
  input  logic [31:0] if_instruction,
  output logic        stop_debug,
  output logic [6:0]  latch_sel,
  input  logic [31:0] latch_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        halted,
  output logic [31:0] cycle_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RUN       = 3'd1;
  localparam logic [2:0] S_STEP      = 3'd2;
  localparam logic [2:0] S_DUMP_SEL  = 3'd3;
  localparam logic [2:0] S_DUMP_LOAD = 3'd4;
  localparam logic [2:0] S_DUMP_TX   = 3'd5;
  localparam logic [2:0] S_DUMP_WAIT = 3'd6;

  localparam logic [1:0] CMD_RUN  = 2'b00;
  localparam logic [1:0] CMD_STEP = 2'b01;
  localparam logic [1:0] CMD_HALT = 2'b10;
  localparam logic [1:0] CMD_DUMP = 2'b11;

  localparam logic [6:0] LAST_WORD = 7'(NUM_LATCH_WORDS - 1);
  localparam logic [2:0] LAST_WAIT = 3'(MUX_LATENCY - 1);

  logic [2:0]  state_q, state_d;
  logic [6:0]  word_q, word_d;       // word index k, also drives latch_sel
  logic [1:0]  byte_q, byte_d;       // byte index b within the current word
  logic [2:0]  wait_q, wait_d;       // mux settle counter in DUMP_SEL
  logic [31:0] shift_q, shift_d;     // outgoing word, MSB byte at [31:24]
  logic [31:0] snap_q, snap_d;       // cycle_count captured at DUMP acceptance
  logic        tail_q, tail_d;       // sending the cycle-count trailer
  logic        stop_q, stop_d;
  logic        ready_q, ready_d;
  logic        halted_q, halted_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] count_q;

  logic accept;
  assign accept = cmd_valid & ready_q;

  // Next-state logic for the run/step/dump sequencer
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    wait_d  = wait_q;
    shift_d = shift_q;
    snap_d  = snap_q;
    tail_d  = tail_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_RUN:  state_d = S_RUN;
            CMD_STEP: state_d = S_STEP;
            CMD_DUMP: begin
              state_d = S_DUMP_SEL;
              word_d  = '0;
              wait_d  = '0;
              tail_d  = 1'b0;
              snap_d  = count_q;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        if ((accept && cmd == CMD_HALT) || if_instruction == HALT_INSTR)
          state_d = S_IDLE;
      end
      S_STEP: state_d = S_IDLE;
      S_DUMP_SEL: begin
        if (wait_q == LAST_WAIT) state_d = S_DUMP_LOAD;
        else                     wait_d  = wait_q + 3'd1;
      end
      S_DUMP_LOAD: begin
        shift_d = latch_data;
        byte_d  = '0;
        state_d = S_DUMP_TX;
      end
      S_DUMP_TX: state_d = S_DUMP_WAIT;
      S_DUMP_WAIT: begin
        if (tx_done) begin
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            shift_d = {shift_q[23:0], 8'h00};
            state_d = S_DUMP_TX;
          end else if (tail_q) begin
            word_d  = '0;
            state_d = S_IDLE;
          end else if (word_q != LAST_WORD) begin
            word_d  = word_q + 7'd1;
            wait_d  = '0;
            state_d = S_DUMP_SEL;
          end else begin
            // Trailer reuses the byte path: load the snapshot as a fifth "word"
            tail_d  = 1'b1;
            shift_d = snap_q;
            byte_d  = '0;
            state_d = S_DUMP_TX;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the cycle after the edge, derived from the next state
  always_comb begin
    stop_d     = !(state_d == S_RUN || state_d == S_STEP);
    ready_d    = (state_d == S_IDLE) || (state_d == S_RUN);
    halted_d   = (state_d == S_IDLE);
    tx_start_d = (state_d == S_DUMP_TX);
    tx_data_d  = (state_d == S_DUMP_TX) ? shift_d[31:24] : tx_data_q;
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      byte_q     <= '0;
      wait_q     <= '0;
      shift_q    <= '0;
      snap_q     <= '0;
      tail_q     <= 1'b0;
      stop_q     <= 1'b1;
      ready_q    <= 1'b1;
      halted_q   <= 1'b1;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_q     <= byte_d;
      wait_q     <= wait_d;
      shift_q    <= shift_d;
      snap_q     <= snap_d;
      tail_q     <= tail_d;
      stop_q     <= stop_d;
      ready_q    <= ready_d;
      halted_q   <= halted_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      count_q    <= count_q + {31'd0, ~stop_q};
    end
  end

  assign cmd_ready   = ready_q;
  assign stop_debug  = stop_q;
  assign latch_sel   = word_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign halted      = halted_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_debug_run_controller.sv
// Randomized self-checking bench for debug_run_controller.
module tb_debug_run_controller;

  localparam int unsigned N    = 24;
  localparam logic [31:0] HALT = 32'hFC000000;
  localparam int unsigned LAT  = 2;

  localparam logic [1:0] C_RUN  = 2'b00;
  localparam logic [1:0] C_STEP = 2'b01;
  localparam logic [1:0] C_HALT = 2'b10;
  localparam logic [1:0] C_DUMP = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic        cmd_ready;
  logic [31:0] if_instruction;
  logic        stop_debug;
  logic [6:0]  latch_sel;
  logic [31:0] latch_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        halted;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  debug_run_controller #(
    .NUM_LATCH_WORDS(N),
    .HALT_INSTR     (HALT),
    .MUX_LATENCY    (LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd           (cmd),
    .cmd_ready     (cmd_ready),
    .if_instruction(if_instruction),
    .stop_debug    (stop_debug),
    .latch_sel     (latch_sel),
    .latch_data    (latch_data),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_done       (tx_done),
    .halted        (halted),
    .cycle_count   (cycle_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Latch mux model: contents appear LAT cycles after latch_sel changes
  logic [31:0] mem [128];
  logic [6:0]  sel_d1, sel_d2;
  always @(posedge clk) begin
    sel_d1 <= latch_sel;
    sel_d2 <= sel_d1;
  end
  assign latch_data = mem[sel_d2];

  // UART model: answers each tx_start with tx_done done_delay cycles later
  logic resp_done = 1'b0;
  logic inj_done  = 1'b0;
  int   done_delay = 3;
  int   cd = 0;
  assign tx_done = resp_done | inj_done;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      resp_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) resp_done = 1'b1;
      end
      if (tx_start === 1'b1) cd = done_delay;
    end
  end

  // Byte capture
  logic [7:0] rx_q [$];
  always @(negedge clk) begin
    if (tx_start === 1'b1) rx_q.push_back(tx_data);
  end

  logic [31:0] model_cc = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] nonhalt();
    logic [31:0] v;
    v = $urandom;
    if (v == HALT) v = 32'h0;
    return v;
  endfunction

  task automatic do_step();
    cmd_valid = 1'b1; cmd = C_STEP; tick();
    // held RUN during the step must not be taken
    cmd = C_RUN;
    check("step_stop", stop_debug, 1'b0);
    check("step_ready", cmd_ready, 1'b0);
    check("step_halted", halted, 1'b0);
    tick();
    cmd_valid = 1'b0;
    model_cc = model_cc + 1;
    check("step_end_stop", stop_debug, 1'b1);
    check("step_end_halted", halted, 1'b1);
    check("step_cc", cycle_count, model_cc);
    tick();
    check("step_after_stop", stop_debug, 1'b1);
    check("step_after_cc", cycle_count, model_cc);
  endtask

  // method: 0 = HALT instruction, 1 = HALT command, 2 = both together
  task automatic do_run(input int n, input int method, input bit drop_dump);
    int tx0;
    int pick;
    tx0 = rx_q.size();
    if_instruction = nonhalt();
    cmd_valid = 1'b1; cmd = C_RUN; tick();
    cmd_valid = 1'b0;
    for (int i = 1; i <= n; i++) begin
      check("run_stop", stop_debug, 1'b0);
      if_instruction = nonhalt();
      cmd_valid = 1'b0;
      if (i == n) begin
        if (method != 1) if_instruction = HALT;
        if (method != 0) begin cmd_valid = 1'b1; cmd = C_HALT; end
      end else if (drop_dump && i == 2) begin
        cmd_valid = 1'b1; cmd = C_DUMP;
      end else if ($urandom_range(0, 3) == 0) begin
        pick = $urandom_range(0, 2);
        cmd_valid = 1'b1;
        cmd = (pick == 0) ? C_RUN : (pick == 1) ? C_STEP : C_DUMP;
      end
      tick();
    end
    cmd_valid = 1'b0;
    if_instruction = nonhalt();
    model_cc = model_cc + n;
    check("run_end_stop", stop_debug, 1'b1);
    check("run_end_halted", halted, 1'b1);
    check("run_end_ready", cmd_ready, 1'b1);
    check("run_cc", cycle_count, model_cc);
    tick();
    check("run_after_cc", cycle_count, model_cc);
    check("run_no_tx", rx_q.size() - tx0, 0);
  endtask

  task automatic do_dump(input int delay, input bit inject);
    logic [7:0]  exp_q [$];
    logic [31:0] w;
    int base, budget, ready_viol, stop_viol, got_n;
    bit injected;
    done_delay = delay;
    for (int k = 0; k < N; k++) begin
      w = mem[k];
      for (int j = 3; j >= 0; j--) exp_q.push_back(w[j*8 +: 8]);
    end
    for (int j = 3; j >= 0; j--) exp_q.push_back(model_cc[j*8 +: 8]);
    base = rx_q.size();
    ready_viol = 0; stop_viol = 0; injected = 1'b0; budget = 0;
    cmd_valid = 1'b1; cmd = C_DUMP; tick();
    cmd_valid = 1'b0;
    while (halted !== 1'b1 && budget < 20000) begin
      if (cmd_ready !== 1'b0) ready_viol++;
      if (stop_debug !== 1'b1) stop_viol++;
      inj_done = 1'b0;
      if (inject && !injected && latch_sel == 7'd3) begin
        inj_done = 1'b1;
        injected = 1'b1;
      end
      tick();
      budget++;
    end
    inj_done = 1'b0;
    check("dump_finished", budget < 20000, 1'b1);
    check("dump_ready_low", ready_viol, 0);
    check("dump_stop_high", stop_viol, 0);
    got_n = rx_q.size() - base;
    check("dump_byte_count", got_n, 4 * N + 4);
    for (int i = 0; i < 4 * int'(N) + 4; i++) begin
      if (i < got_n) check("dump_byte", rx_q[base + i], exp_q[i]);
    end
    check("dump_end_sel", latch_sel, 7'd0);
    check("dump_end_ready", cmd_ready, 1'b1);
    check("dump_end_cc", cycle_count, model_cc);
  endtask

  initial begin
    int budget;
    int tx0;
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | i;
    reset = 1'b0; cmd_valid = 1'b1; cmd = C_RUN; if_instruction = nonhalt();

    // Reset held with a command pending
    repeat (3) begin
      tick();
      check("rst_stop", stop_debug, 1'b1);
      check("rst_halted", halted, 1'b1);
      check("rst_cc", cycle_count, 0);
      check("rst_tx_start", tx_start, 1'b0);
      check("rst_ready", cmd_ready, 1'b1);
      check("rst_sel", latch_sel, 7'd0);
      check("rst_tx_data", tx_data, 8'd0);
    end
    check("rst_no_bytes", rx_q.size(), 0);
    cmd_valid = 1'b0;
    reset = 1'b1;
    tick();

    do_step();
    do_step();
    check("two_steps_cc", cycle_count, 2);

    do_run(10, 0, 1'b0);
    do_run(10, 2, 1'b0);
    do_run(5, 1, 1'b1);

    repeat (12) begin
      if ($urandom_range(0, 2) == 0) do_step();
      else do_run($urandom_range(1, 30), $urandom_range(0, 2), $urandom_range(0, 1) == 1);
    end

    do_dump(3, 1'b1);

    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    do_dump($urandom_range(1, 6), 1'b0);
    do_run($urandom_range(1, 20), $urandom_range(0, 2), 1'b0);

    // Reset in DUMP_WAIT of word 5, then a fresh dump from word 0
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | i;
    done_delay = 3;
    cmd_valid = 1'b1; cmd = C_DUMP; tick();
    cmd_valid = 1'b0;
    budget = 0;
    while (!(tx_start === 1'b1 && latch_sel == 7'd5) && budget < 5000) begin
      tick();
      budget++;
    end
    check("middump_reached_w5", budget < 5000, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_cc = '0;
    check("middump_halted", halted, 1'b1);
    check("middump_tx_start", tx_start, 1'b0);
    check("middump_sel", latch_sel, 7'd0);
    check("middump_ready", cmd_ready, 1'b1);
    check("middump_stop", stop_debug, 1'b1);
    check("middump_cc", cycle_count, 0);
    tx0 = rx_q.size();
    repeat (5) tick();
    check("middump_quiet", rx_q.size() - tx0, 0);
    do_dump(3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
